// File: rtl/led_seq_pkg.sv
// Shared constants and helpers for the LED sequencing counter.
package led_seq_pkg;

   localparam logic [1:0] MODE_UP     = 2'b00;
   localparam logic [1:0] MODE_DOWN   = 2'b01;
   localparam logic [1:0] MODE_BOUNCE = 2'b10;
   localparam logic [1:0] MODE_GRAY   = 2'b11;

   function automatic logic [31:0] bin2gray(input logic [31:0] bin);
      return bin ^ (bin >> 1);
   endfunction

endpackage

// File: rtl/led_seq_counter_if.sv
// Control/status bundle between a controller and the LED sequencing counter.
interface led_seq_counter_if #(
   parameter int WIDTH    = 5,
   parameter int PWM_BITS = 4
);
   logic                en;
   logic                clr;
   logic [1:0]          mode;
   logic [WIDTH-1:0]    max_val;
   logic [PWM_BITS-1:0] duty;
   logic [WIDTH-1:0]    count;
   logic                tick;
   logic                wrap;
   logic [WIDTH-1:0]    led;

   modport master (output en, clr, mode, max_val, duty,
                   input  count, tick, wrap, led);
   modport slave  (input  en, clr, mode, max_val, duty,
                   output count, tick, wrap, led);
endinterface

// File: rtl/led_prescaler.sv
// Free-running prescaler: step pulses once every 2**LOG2DELAY enabled clocks.
module led_prescaler #(
   parameter int LOG2DELAY = 21
) (
   input  logic clk,
   input  logic resetn,
   input  logic en,
   input  logic clr,
   output logic step
);

   generate
      if (LOG2DELAY == 0) begin : g_direct
         logic unused_s;
         assign unused_s = clk ^ resetn ^ clr;
         assign step     = en;
      end else begin : g_count
         logic [LOG2DELAY-1:0] pre_r;

         // prescale counter, frozen while disabled
         always_ff @(posedge clk or negedge resetn) begin
            if (!resetn) begin
               pre_r <= '0;
            end else if (clr) begin
               pre_r <= '0;
            end else if (en) begin
               pre_r <= pre_r + LOG2DELAY'(1'b1);
            end else begin
               pre_r <= pre_r;
            end
         end

         assign step = en && (pre_r == '1);
      end
   endgenerate

endmodule

// File: rtl/led_seq_counter.sv
// LED sequencing counter: prescaled up/down/bounce/gray count with PWM-dimmed LED outputs.
module led_seq_counter
   import led_seq_pkg::*;
#(
   parameter int WIDTH     = 5,
   parameter int LOG2DELAY = 21,
   parameter int PWM_BITS  = 4
) (
   input  logic               clk,
   input  logic               resetn,
   led_seq_counter_if.slave   bus
);

   localparam logic [0:0]       UP_DIR   = 1'b0;
   localparam logic [0:0]       DOWN_DIR = 1'b1;
   localparam logic [WIDTH-1:0] ONE      = WIDTH'(1'b1);

   logic                step_s;
   logic [WIDTH-1:0]    cnt_r, cnt_nxt_s, clr_val_s, count_src_s, count_nxt_s;
   logic [0:0]          dir_r, dir_nxt_s;
   logic                wrap_nxt_s, going_down_s, on_s;
   logic [WIDTH-1:0]    count_r, led_r;
   logic                tick_r, wrap_r;
   logic [PWM_BITS-1:0] pwm_r;

   led_prescaler #(.LOG2DELAY(LOG2DELAY)) u_prescaler (
      .clk    (clk),
      .resetn (resetn),
      .en     (bus.en),
      .clr    (bus.clr),
      .step   (step_s)
   );

   // next count/direction; anything that is not BOUNCE leaves the direction at up
   always_comb begin
      cnt_nxt_s    = cnt_r;
      dir_nxt_s    = UP_DIR;
      wrap_nxt_s   = 1'b0;
      going_down_s = ((dir_r == DOWN_DIR) && (cnt_r != '0)) || (cnt_r == bus.max_val);
      if (cnt_r > bus.max_val) begin
         cnt_nxt_s  = (bus.mode == MODE_DOWN) ? bus.max_val : '0;
         wrap_nxt_s = 1'b1;
      end else begin
         case (bus.mode)
            MODE_DOWN: begin
               if (cnt_r == '0) begin
                  cnt_nxt_s  = bus.max_val;
                  wrap_nxt_s = 1'b1;
               end else begin
                  cnt_nxt_s  = cnt_r - ONE;
               end
            end
            MODE_BOUNCE: begin
               if (bus.max_val == '0) begin
                  cnt_nxt_s  = '0;
                  wrap_nxt_s = 1'b1;
               end else if (going_down_s) begin
                  cnt_nxt_s = cnt_r - ONE;
                  if (cnt_r == ONE) begin
                     wrap_nxt_s = 1'b1;
                  end else begin
                     dir_nxt_s  = DOWN_DIR;
                  end
               end else begin
                  cnt_nxt_s = cnt_r + ONE;
                  if ((cnt_r + ONE) == bus.max_val) begin
                     wrap_nxt_s = 1'b1;
                     dir_nxt_s  = DOWN_DIR;
                  end else begin
                     dir_nxt_s  = UP_DIR;
                  end
               end
            end
            default: begin
               if (cnt_r == bus.max_val) begin
                  cnt_nxt_s  = '0;
                  wrap_nxt_s = 1'b1;
               end else begin
                  cnt_nxt_s  = cnt_r + ONE;
               end
            end
         endcase
      end
   end

   assign clr_val_s   = (bus.mode == MODE_DOWN) ? bus.max_val : '0;
   assign count_src_s = bus.clr ? clr_val_s : cnt_nxt_s;
   assign count_nxt_s = (bus.mode == MODE_GRAY) ? WIDTH'(bin2gray(32'(count_src_s))) : count_src_s;

   // counter state and status strobes; clear wins over a pending step
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         cnt_r   <= '0;
         dir_r   <= UP_DIR;
         count_r <= '0;
         tick_r  <= 1'b0;
         wrap_r  <= 1'b0;
      end else if (bus.clr) begin
         cnt_r   <= clr_val_s;
         dir_r   <= UP_DIR;
         count_r <= count_nxt_s;
         tick_r  <= 1'b0;
         wrap_r  <= 1'b0;
      end else if (step_s) begin
         cnt_r   <= cnt_nxt_s;
         dir_r   <= dir_nxt_s;
         count_r <= count_nxt_s;
         tick_r  <= 1'b1;
         wrap_r  <= wrap_nxt_s;
      end else begin
         tick_r  <= 1'b0;
         wrap_r  <= 1'b0;
      end
   end

   assign on_s = (bus.duty == '1) || (pwm_r < bus.duty);

   // free-running PWM phase and dimmed LED register
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         pwm_r <= '0;
         led_r <= '0;
      end else begin
         pwm_r <= pwm_r + PWM_BITS'(1'b1);
         led_r <= count_r & {WIDTH{on_s}};
      end
   end

   assign bus.count = count_r;
   assign bus.tick  = tick_r;
   assign bus.wrap  = wrap_r;
   assign bus.led   = led_r;

endmodule
